debug_frame_sender: RTL and testbench
=====================================

# debug_frame_sender

Debugger-unit transmitter that answers the step/run controller's send request. On a one-cycle `is_start_send` pulse it snapshots the cycle counter and PC, then reads the register file and data memory through synchronous debug read ports. It serializes the whole frame byte by byte to the UART transmitter and pulses `os_done_send` when the last byte has been sent.

## Interface
- `NB_DATA`, 32: word width. The serializer is fixed at 4 bytes per word.
- `NB_REG_ADDR`, 5: register address width. Registers sent = 2**NB_REG_ADDR.
- `N_MEM_WORDS`, 16: number of data-memory words sent, at addresses 0..N_MEM_WORDS-1.
- `NB_MEM_ADDR`, 5: memory address width. Requires N_MEM_WORDS ≤ 2**NB_MEM_ADDR.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-low.
- `is_start_send` in 1: frame request pulse.
- `i_clk_count` in 32: cycle counter from the step controller.
- `i_pc` in 32: current PC.
- `o_reg_addr` out NB_REG_ADDR: register-file debug read address.
- `i_reg_data` in 32: register data. Valid the cycle after the address is presented.
- `o_mem_addr` out NB_MEM_ADDR: data-memory debug read address (word address).
- `i_mem_data` in 32: memory data. Valid the cycle after the address is presented.
- `o_tx_data` out 8: byte to the UART transmitter.
- `o_tx_start` out 1: one-cycle start pulse to the UART transmitter.
- `is_tx_done` in 1: one-cycle pulse from the UART when a byte has been sent.
- `os_done_send` out 1: one-cycle frame-complete pulse.
- `o_busy` out 1: high from frame acceptance until the `os_done_send` cycle, inclusive.

## Operation
- Frame word order (W = 2 + 2**NB_REG_ADDR + N_MEM_WORDS words, 4·W bytes):
  - word 0: clk_count;
  - word 1: pc;
  - words 2..: reg[0..2**NB_REG_ADDR-1];
  - then mem[0..N_MEM_WORDS-1].
- Each word is sent MSB byte first.
- `i_clk_count` and `i_pc` are latched in the cycle `is_start_send` is accepted. Later changes do not affect the frame.
- Counters:
  - `word_idx`: 0..W-1.
  - `byte_idx`: 0..3, 2 bits.
  - `shift_reg`: 32 bits.
  - `o_tx_data` = shift_reg[31:24] at all times.
- Address outputs are registered and updated on entry to LOAD:
  - `o_reg_addr` = word_idx-2 when word_idx is in the register range, else held.
  - `o_mem_addr` = word_idx-2-2**NB_REG_ADDR when word_idx is in the memory range, else held.
- States:
  - IDLE: if `is_start_send`, latch snapshots, clear word_idx/byte_idx, go to LOAD. Otherwise stay.
  - LOAD: addresses valid at the RAM. Go to READ.
  - READ: load `shift_reg` from the source selected by word_idx (snapshot, `i_reg_data` or `i_mem_data`). Clear byte_idx. Go to SEND.
  - SEND: `o_tx_start`=1 for exactly this cycle. Go to WAIT_TX.
  - WAIT_TX: wait for `is_tx_done`. On done:
    - if byte_idx<3: byte_idx++, shift_reg <<= 8, go to SEND;
    - else if word_idx<W-1: word_idx++, go to LOAD;
    - else go to DONE.
  - DONE: `os_done_send`=1. Go to IDLE.
- `is_start_send` outside IDLE is ignored; it is neither queued nor used to restart.
- `is_tx_done` outside WAIT_TX is ignored.
- Reset values: state IDLE; all counters and `shift_reg` 0.
  - Outputs: `o_tx_data`=0, `o_tx_start`=0, `os_done_send`=0, `o_busy`=0, `o_reg_addr`=0, `o_mem_addr`=0.
- Reset asserted mid-frame aborts the frame: no further `o_tx_start`, and no `os_done_send`.

## Timing
- `is_start_send` sampled high at edge N → LOAD at N+1, READ at N+2, first `o_tx_start` high in cycle N+3.
- `o_tx_start` and `os_done_send` are Moore outputs, decoded from state only.
- `o_tx_data` is stable from the SEND cycle until `is_tx_done` is sampled.
- After `is_tx_done` at edge M:
  - the next byte of the same word has `o_tx_start` at M+1;
  - the first byte of the next word has `o_tx_start` at M+3 (LOAD, READ, SEND).
- After `is_tx_done` for the final byte at edge M, `os_done_send` is high during cycle M+1. `o_busy` drops at M+2.
- `is_tx_done` arriving in the first WAIT_TX cycle (zero-wait UART) is legal. The minimum byte period is then 2 cycles.

## Test plan
- Basic frame: clk_count=0x12345678, pc=0x00000040, reg[i]=i, mem[j]=0xA0000000+j, UART model with done 5 cycles after start.
  - Byte stream begins 12 34 56 78 00 00 00 40 00 00 00 00 00 00 00 01.
  - The last 4 bytes are A0 00 00 0F.
  - Exactly 200 `o_tx_start` pulses, then one `os_done_send` pulse.
- Snapshot: change `i_clk_count` to 0xFFFFFFFF one cycle after start → frame still carries 0x12345678.
- Address sequence: check that `o_reg_addr` steps 0..31 and `o_mem_addr` steps 0..15, each held through its READ cycle.
- Zero-wait UART: `is_tx_done` in the first WAIT_TX cycle → byte period is 2 cycles. Full frame completes with correct data.
- Start while busy: pulse `is_start_send` at byte 50 → ignored. Exactly one `os_done_send` pulse, 200 bytes total.
- Reset mid-frame at byte 10: all outputs are 0 on the next edge and no `os_done_send`. A new start afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/debug_frame_sender_if.sv
// debug_frame_sender_if: debug read ports, UART byte handshake and frame request/complete signals
interface debug_frame_sender_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int NB_MEM_ADDR = 5
);
  logic                   is_start_send;
  logic [NB_DATA-1:0]     i_clk_count;
  logic [NB_DATA-1:0]     i_pc;
  logic [NB_REG_ADDR-1:0] o_reg_addr;
  logic [NB_DATA-1:0]     i_reg_data;
  logic [NB_MEM_ADDR-1:0] o_mem_addr;
  logic [NB_DATA-1:0]     i_mem_data;
  logic [7:0]             o_tx_data;
  logic                   o_tx_start;
  logic                   is_tx_done;
  logic                   os_done_send;
  logic                   o_busy;
  modport master (
    input  is_start_send, i_clk_count, i_pc, i_reg_data, i_mem_data, is_tx_done,
    output o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, os_done_send, o_busy
  );
  modport slave (
    output is_start_send, i_clk_count, i_pc, i_reg_data, i_mem_data, is_tx_done,
    input  o_reg_addr, o_mem_addr, o_tx_data, o_tx_start, os_done_send, o_busy
  );
endinterface

// File: rtl/debug_frame_sender.sv
// debug_frame_sender: serializes clk_count, pc, register file and data memory to the UART, MSB byte first
module debug_frame_sender #(
  parameter int NB_REG_ADDR = 5,
  parameter int N_MEM_WORDS = 16,
  parameter int NB_MEM_ADDR = 5
) (
  input  logic clk,
  input  logic rst,
  debug_frame_sender_if.master bus
);
  localparam int NREG = 2 ** NB_REG_ADDR;
  localparam int W = 2 + NREG + N_MEM_WORDS;
  localparam int WB = $clog2(W);
  localparam logic [WB-1:0] MEM_LO = WB'(2 + NREG);
  localparam logic [WB-1:0] LAST = WB'(W - 1);
  typedef enum logic [2:0] {IDLE, LOAD, READ, SEND, WAIT_TX, DONE} state_t;
  state_t state_q, state_d;
  logic [WB-1:0] word_q, word_d;
  logic [1:0] byte_q, byte_d;
  logic [31:0] shift_q, shift_d, cnt_q, cnt_d, pc_q, pc_d;
  logic [NB_REG_ADDR-1:0] reg_addr_q, reg_addr_d;
  logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      byte_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
    end
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_d     = byte_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    reg_addr_d = reg_addr_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: if (bus.is_start_send) begin
        cnt_d   = bus.i_clk_count;
        pc_d    = bus.i_pc;
        word_d  = '0;
        byte_d  = '0;
        state_d = LOAD;
      end
      LOAD: state_d = READ;
      READ: begin
        shift_d = word_q == '0 ? cnt_q : word_q == WB'(1) ? pc_q :
                  word_q < MEM_LO ? bus.i_reg_data : bus.i_mem_data;
        byte_d  = '0;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: if (bus.is_tx_done) begin
        if (byte_q != 2'd3) begin
          byte_d  = byte_q + 2'd1;
          shift_d = shift_q << 8;
          state_d = SEND;
        end else if (word_q != LAST) begin
          word_d  = word_q + WB'(1);
          state_d = LOAD;
        end else
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // read addresses are registered on entry to LOAD so the RAM sees them one cycle before READ
    if (state_d == LOAD) begin
      reg_addr_d = (word_d >= WB'(2) && word_d < MEM_LO) ? NB_REG_ADDR'(word_d - WB'(2)) : reg_addr_q;
      mem_addr_d = word_d >= MEM_LO ? NB_MEM_ADDR'(word_d - MEM_LO) : mem_addr_q;
    end
  end
  assign bus.o_tx_data    = shift_q[31:24];
  assign bus.o_tx_start   = state_q == SEND;
  assign bus.os_done_send = state_q == DONE;
  assign bus.o_busy       = state_q != IDLE;
  assign bus.o_reg_addr   = reg_addr_q;
  assign bus.o_mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_debug_frame_sender.sv
// tb_debug_frame_sender: byte-stream and cycle-timing model of the debug frame, checked every cycle
module tb_debug_frame_sender;
  logic clk = 0, rst = 0;
  int cyc = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  debug_frame_sender_if #(.NB_DATA(32), .NB_REG_ADDR(5), .NB_MEM_ADDR(5)) bus ();
  debug_frame_sender #(.NB_REG_ADDR(5), .N_MEM_WORDS(16), .NB_MEM_ADDR(5)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic [31:0] regf [32];
  logic [31:0] memf [32];
  logic [7:0] exp_q [$];
  logic [7:0] rec [$];
  int rec_cyc [$];
  logic [7:0] cur;
  logic [7:0] head [16];
  logic [7:0] tail [4];
  logic [7:0] head3 [8];
  int dly = 4, cnt = 0, pos = 0, acc_cyc = 0, next_start = -1, done_cyc = -1, end_cyc = -1;
  int nstart = 0, ndone = 0, k, w;
  bit active = 0, waiting = 0, chk_zero = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_word(input logic [31:0] v);
    for (int b = 3; b >= 0; b--) exp_q.push_back(v[b*8+:8]);
  endtask

  // synchronous debug read ports: data valid the cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.i_reg_data <= regf[bus.o_reg_addr];
    bus.i_mem_data <= memf[bus.o_mem_addr];
  end

  // k is the index of the edge that ends the current cycle
  always @(negedge clk) begin
    k = cyc + 1;
    if (chk_zero) begin
      chk("reset_outputs", {bus.o_tx_data, bus.o_tx_start, bus.os_done_send, bus.o_busy,
                            bus.o_reg_addr, bus.o_mem_addr}, 0);
      chk_zero = 0;
    end
    if (!rst) begin
      chk_zero = 1;
      active = 0;
      waiting = 0;
      exp_q.delete();
      next_start = -1;
      done_cyc = -1;
      end_cyc = -1;
      bus.is_tx_done = 0;
    end else begin
      chk("tx_start", bus.o_tx_start, k == next_start);
      chk("done_send", bus.os_done_send, k == done_cyc);
      chk("busy", bus.o_busy, active && k >= acc_cyc);
      if (bus.o_tx_start) nstart++;
      if (bus.os_done_send) ndone++;
      if (active && next_start == k + 1 && pos % 4 == 0) begin
        w = pos / 4;
        if (w >= 2 && w < 34) chk("reg_addr", bus.o_reg_addr, w - 2);
        else if (w >= 34) chk("mem_addr", bus.o_mem_addr, w - 34);
      end
      bus.is_tx_done = 0;
      if (bus.o_tx_start && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("tx_data", bus.o_tx_data, cur);
        rec.push_back(bus.o_tx_data);
        rec_cyc.push_back(k);
        pos++;
        cnt = dly;
        waiting = 1;
        next_start = -1;
      end else if (waiting) begin
        chk("tx_data_hold", bus.o_tx_data, cur);
        if (cnt == 0) begin
          bus.is_tx_done = 1;
          waiting = 0;
          if (pos % 4 != 0) next_start = k + 1;
          else if (exp_q.size() > 0) next_start = k + 3;
          else begin
            done_cyc = k + 1;
            end_cyc = k + 1;
          end
        end else cnt--;
      end
      if (bus.is_start_send && !active) begin
        active = 1;
        acc_cyc = k + 1;
        next_start = k + 3;
        done_cyc = -1;
        end_cyc = -1;
        pos = 0;
        nstart = 0;
        ndone = 0;
        rec.delete();
        rec_cyc.delete();
        exp_q.delete();
        push_word(bus.i_clk_count);
        push_word(bus.i_pc);
        for (int i = 0; i < 32; i++) push_word(regf[i]);
        for (int j = 0; j < 16; j++) push_word(memf[j]);
      end
      if (active && end_cyc >= 0 && k >= end_cyc) active = 0;
    end
  end

  task automatic send(input logic [31:0] cc, input logic [31:0] pc, input bit scramble);
    @(posedge clk);
    #1 bus.i_clk_count = cc;
    bus.i_pc = pc;
    bus.is_start_send = 1;
    @(posedge clk);
    #1 bus.is_start_send = 0;
    if (scramble) begin
      bus.i_clk_count = 32'hFFFFFFFF;
      bus.i_pc = 32'hDEADBEEF;
    end
  endtask

  task automatic wait_starts(input int n);
    int t = 0;
    while (nstart < n && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("wait_starts_timeout", nstart >= n, 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (ndone == 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    chk("done_timeout", ndone > 0, 1);
    repeat (3) @(posedge clk);
    chk("n_start", nstart, 200);
    chk("n_done", ndone, 1);
  endtask

  initial begin
    head = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h40,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    tail = '{8'hA0, 8'h00, 8'h00, 8'h0F};
    head3 = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 32; i++) begin
      regf[i] = i;
      memf[i] = 32'hA0000000 + i;
    end
    bus.is_start_send = 0;
    bus.i_clk_count = 0;
    bus.i_pc = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    // basic frame, snapshot inputs change right after acceptance
    dly = 4;
    send(32'h12345678, 32'h00000040, 1);
    wait_done();
    for (int i = 0; i < 16; i++) chk("head_byte", rec[i], head[i]);
    for (int i = 0; i < 4; i++) chk("tail_byte", rec[196+i], tail[i]);
    chk("byte_period_slow", rec_cyc[1] - rec_cyc[0], 6);
    // zero-wait UART with an ignored start at byte 50
    dly = 0;
    send(32'h12345678, 32'h00000040, 0);
    wait_starts(50);
    #1 bus.is_start_send = 1;
    @(posedge clk);
    #1 bus.is_start_send = 0;
    wait_done();
    chk("byte_period_fast", rec_cyc[1] - rec_cyc[0], 2);
    chk("word_period_fast", rec_cyc[4] - rec_cyc[3], 4);
    for (int i = 0; i < 4; i++) chk("tail_byte_fast", rec[196+i], tail[i]);
    // reset mid-frame, then a fresh frame
    dly = 4;
    send(32'h12345678, 32'h00000040, 0);
    wait_starts(10);
    #1 rst = 0;
    @(posedge clk);
    #1 rst = 1;
    repeat (20) @(posedge clk);
    chk("abort_starts", nstart, 10);
    chk("abort_done", ndone, 0);
    send(32'hCAFEBABE, 32'h00000100, 0);
    wait_done();
    for (int i = 0; i < 8; i++) chk("head_byte_after_reset", rec[i], head3[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
